// File: rtl/stage_if_fq_if.sv
// Instruction-memory request/response port for the fetch stage.
// master: fetch side (req/addr out); slave: memory (busy/rvalid/data out).
interface stage_if_fq_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_busy;
  logic        instr_rvalid;
  logic [31:0] instr_data;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_busy,
    input  instr_rvalid,
    input  instr_data
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_busy,
    output instr_rvalid,
    output instr_data
  );
endinterface

// File: rtl/stage_if_fq.sv
// Fetch stage with a DEPTH-entry {pc,instr} queue ahead of decode.
// Ports: clk/rst_n, mem (request port), redirect + stall in, head out.
module stage_if_fq #(
  parameter logic [31:0] RESET_VEC = 32'h0,
  parameter int          DEPTH     = 4,
  localparam int         PW        = $clog2(DEPTH),
  localparam int         CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  stage_if_fq_if.master mem,
  input  logic          i_exn,
  input  logic [5:0]    i_exn_type,
  input  logic          i_eret,
  input  logic [31:0]   i_elr,
  input  logic          i_br_taken,
  input  logic [31:0]   i_br_dest,
  input  logic          i_id_stall,
  output logic          o_if_valid,
  output logic [31:0]   o_if_pc,
  output logic [31:0]   o_if_instr,
  output logic [CW-1:0] o_fq_count
);

  logic [31:0]   r_fpc;
  logic [31:0]   r_rsp_pc;
  logic          r_pend;
  logic          r_drop;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rp;
  logic [PW-1:0] r_wp;
  logic [63:0]   r_mem [DEPTH];

  logic          w_flush;
  logic [31:0]   w_target;
  logic [CW:0]   w_occ;
  logic          w_room;
  logic          w_req;
  logic          w_acc;
  logic          w_rsp;
  logic          w_enq;
  logic          w_valid;
  logic          w_deq;
  logic [63:0]   w_head;

  assign w_flush = i_exn | i_br_taken;

  always_comb begin
    w_target = i_br_dest;
    unique case (1'b1)
      (i_exn && i_eret):  w_target = i_elr;
      (i_exn && !i_eret): w_target = {RESET_VEC[31:8],
                                      i_exn_type, 2'b00};
      default:            w_target = i_br_dest;
    endcase
  end

  // Reserve a slot for the outstanding response too.
  assign w_occ   = {1'b0, r_count} + (CW+1)'(r_pend);
  assign w_room  = w_occ < (CW+1)'(DEPTH);
  assign w_req   = rst_n & ~w_flush & w_room &
                   (~r_pend | mem.instr_rvalid);
  assign w_acc   = w_req & ~mem.instr_busy;
  assign w_rsp   = mem.instr_rvalid & r_pend;
  assign w_enq   = w_rsp & ~r_drop & ~w_flush;
  assign w_valid = r_count != '0;
  assign w_deq   = w_valid & ~i_id_stall & ~w_flush;
  assign w_head  = r_mem[r_rp];

  assign mem.instr_req  = w_req;
  assign mem.instr_addr = r_fpc;
  assign o_if_valid     = w_valid;
  assign o_if_pc        = w_valid ? w_head[63:32] : 32'h0;
  assign o_if_instr     = w_valid ? w_head[31:0]  : 32'h0;
  assign o_fq_count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc    <= RESET_VEC;
      r_rsp_pc <= '0;
      r_pend   <= 1'b0;
      r_drop   <= 1'b0;
      r_count  <= '0;
      r_rp     <= '0;
      r_wp     <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_flush) begin
      r_fpc   <= w_target;
      r_count <= '0;
      r_rp    <= '0;
      r_wp    <= '0;
      // A response still in flight belongs to the old stream.
      r_pend  <= r_pend & ~mem.instr_rvalid;
      r_drop  <= r_pend & ~mem.instr_rvalid;
    end else begin
      if (w_acc) begin
        r_pend   <= 1'b1;
        r_fpc    <= r_fpc + 32'd4;
        r_rsp_pc <= r_fpc;
      end else if (w_rsp) begin
        r_pend <= 1'b0;
      end
      if (w_rsp && r_drop)
        r_drop <= 1'b0;
      if (w_enq) begin
        r_mem[r_wp] <= {r_rsp_pc, mem.instr_data};
        r_wp        <= r_wp + PW'(1);
      end
      if (w_deq)
        r_rp <= r_rp + PW'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if_fq.sv
// Scoreboard bench for stage_if_fq: memory model, directed + random.
// Expected decode stream is the sequential pc run from the last target.
module tb_stage_if_fq;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_if_fq_if mif ();

  logic        exn, eret, br_taken, id_stall;
  logic [5:0]  exn_type;
  logic [31:0] elr, br_dest;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic [2:0]  fq_count;

  stage_if_fq #(.RESET_VEC(RV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mif),
    .i_exn      (exn),
    .i_exn_type (exn_type),
    .i_eret     (eret),
    .i_elr      (elr),
    .i_br_taken (br_taken),
    .i_br_dest  (br_dest),
    .i_id_stall (id_stall),
    .o_if_valid (if_valid),
    .o_if_pc    (if_pc),
    .o_if_instr (if_instr),
    .o_fq_count (fq_count)
  );

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [31:0] exp_q [$];

  bit          acc;
  logic [31:0] acc_addr;
  bit          prev_hold;
  logic [31:0] prev_addr;
  logic        fl;
  logic [31:0] e;

  bit          m_pend;
  int          m_wait;
  logic [31:0] m_addr;
  int          lat_fix;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] tgt(
    input logic x, input logic r, input logic [5:0] t,
    input logic [31:0] l, input logic [31:0] d);
    if (x && r) return l;
    if (x)      return {RV[31:8], t, 2'b00};
    return d;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 256; i++)
      exp_q.push_back(t + 32'(4 * i));
  endtask

  // Monitor: pops the scoreboard whenever decode takes the head.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc       = 1'b0;
      prev_hold = 1'b0;
    end else begin
      fl = exn | br_taken;
      if (prev_hold)
        chk("addr_hold", mif.instr_addr, prev_addr);
      prev_hold = mif.instr_req & mif.instr_busy & ~fl;
      prev_addr = mif.instr_addr;
      if (fl)
        chk("req_in_flush", mif.instr_req, 1'b0);
      chk("valid_vs_count", if_valid, fq_count != 0);
      chk("count_max", fq_count <= DEPTH, 1'b1);
      if (if_valid && !id_stall && !fl) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: pc %h", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", if_pc, e);
          chk("pop_instr", if_instr, mdata(e));
        end
      end
      acc      = mif.instr_req & ~mif.instr_busy;
      acc_addr = mif.instr_addr;
    end
  end

  // One clock: clear pulses, then advance the memory model.
  task automatic cyc();
    @(posedge clk);
    #1;
    exn      = 1'b0;
    eret     = 1'b0;
    br_taken = 1'b0;
    if (mif.instr_rvalid) begin
      mif.instr_rvalid = 1'b0;
      m_pend = 1'b0;
    end
    if (acc) begin
      m_pend = 1'b1;
      m_addr = acc_addr;
      m_wait = (lat_fix > 0) ? lat_fix - 1
                             : int'($urandom_range(2, 0));
    end
    if (m_pend && !mif.instr_rvalid) begin
      if (m_wait == 0) begin
        mif.instr_rvalid = 1'b1;
        mif.instr_data   = mdata(m_addr);
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] pc);
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge clk);
      if (if_valid) break;
    end
    chk({nm, "_valid"}, if_valid, 1'b1);
    chk({nm, "_pc"}, if_pc, pc);
  endtask

  logic [31:0] a, t;
  bit found;
  int p0, r;

  initial begin
    exn = 0; eret = 0; br_taken = 0; id_stall = 0;
    exn_type = 0; elr = 0; br_dest = 0;
    mif.instr_busy = 0; mif.instr_rvalid = 0; mif.instr_data = 0;
    m_pend = 0; m_wait = 0; m_addr = 0; lat_fix = 1;
    redirect(RV);

    repeat (2) @(negedge clk);
    chk("rst_req", mif.instr_req, 1'b0);
    chk("rst_addr", mif.instr_addr, RV);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_count", fq_count, 3'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("c0_req", mif.instr_req, 1'b1);
    chk("c0_addr", mif.instr_addr, RV);
    cyc(); @(negedge clk);
    chk("c1_addr", mif.instr_addr, RV + 4);
    chk("c1_valid", if_valid, 1'b0);
    cyc(); @(negedge clk);
    chk("c2_valid", if_valid, 1'b1);
    chk("c2_pc", if_pc, RV);
    for (int i = 1; i < 6; i++) begin
      cyc(); @(negedge clk);
      chk("stream_valid", if_valid, 1'b1);
      chk("stream_pc", if_pc, RV + 32'(4 * i));
    end

    cyc(); id_stall = 1'b1;
    repeat (9) cyc();
    @(negedge clk);
    chk("stall_count", fq_count, 3'd4);
    chk("stall_req", mif.instr_req, 1'b0);
    cyc(); id_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("drain_valid", if_valid, 1'b1);
      cyc();
    end

    repeat (3) cyc();
    mif.instr_busy = 1'b1;
    @(negedge clk);
    a = mif.instr_addr;
    chk("busy_req", mif.instr_req, 1'b1);
    repeat (2) begin
      cyc(); @(negedge clk);
      chk("busy_addr", mif.instr_addr, a);
      chk("busy_req", mif.instr_req, 1'b1);
    end
    cyc(); mif.instr_busy = 1'b0;
    @(negedge clk);
    chk("busy_last", mif.instr_addr, a);
    cyc(); @(negedge clk);
    chk("busy_once", mif.instr_addr, a + 4);

    lat_fix = 3;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (acc) begin
        found = 1;
        break;
      end
    end
    chk("exn_setup", found, 1'b1);
    exn = 1'b1; exn_type = 6'h05;
    t = tgt(1'b1, 1'b0, 6'h05, elr, br_dest);
    redirect(t);
    lat_fix = 1;
    @(negedge clk);
    chk("exn_req", mif.instr_req, 1'b0);
    cyc(); @(negedge clk);
    chk("exn_valid", if_valid, 1'b0);
    chk("exn_count", fq_count, 3'd0);
    chk("exn_addr", mif.instr_addr, 32'h114);
    chk("exn_wait", mif.instr_req, 1'b0);
    wait_valid("exn", 32'h114);

    cyc();
    exn = 1; eret = 1; elr = 32'h2000;
    br_taken = 1; br_dest = 32'h3000;
    redirect(32'h2000);
    cyc(); @(negedge clk);
    chk("eret_addr", mif.instr_addr, 32'h2000);
    wait_valid("eret", 32'h2000);

    cyc(); id_stall = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    chk("full_count", fq_count, 3'd4);
    cyc();
    br_taken = 1'b1; br_dest = 32'h3000;
    redirect(32'h3000);
    cyc(); @(negedge clk);
    chk("br_valid", if_valid, 1'b0);
    chk("br_count", fq_count, 3'd0);
    id_stall = 1'b0;
    wait_valid("br", 32'h3000);
    chk("br_instr", if_instr, mdata(32'h3000));

    lat_fix = 0;
    p0 = pops;
    repeat (1500) begin
      cyc();
      id_stall       = ($urandom_range(9, 0) < 3);
      mif.instr_busy = ($urandom_range(3, 0) == 0);
      r = int'($urandom_range(99, 0));
      if (r < 3) begin
        exn      = 1'b1;
        eret     = ($urandom_range(2, 0) == 0);
        exn_type = 6'($urandom);
        elr      = $urandom & 32'hFFFF_FFFC;
        br_taken = $urandom_range(1, 0) == 1;
        br_dest  = $urandom & 32'hFFFF_FFFC;
        redirect(tgt(exn, eret, exn_type, elr, br_dest));
      end else if (r < 7) begin
        br_taken = 1'b1;
        br_dest  = $urandom & 32'hFFFF_FFFC;
        redirect(br_dest);
      end
    end
    cyc();
    @(negedge clk);
    chk("progress", (pops - p0) > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
